// File: rtl/pc_stack_if.sv
// pc_stack_if: prefetch <-> pc_stack bundle.
// master (prefetch side): drives instr_addr, pc_l, isp_push, isp_pop, itr;
//   sees addr, flush, itr_act, depth, ovf, unf.
// slave (pc_stack side): the mirror image of master.
interface pc_stack_if #(
    parameter int MINSTW = 8,
    parameter int SPW    = 4
);
    logic [MINSTW-1:0] instr_addr;
    logic              pc_l;
    logic              isp_push;
    logic              isp_pop;
    logic              itr;
    logic [MINSTW-1:0] addr;
    logic              flush;
    logic              itr_act;
    logic [SPW-1:0]    depth;
    logic              ovf;
    logic              unf;

    modport master (
        output instr_addr, pc_l, isp_push, isp_pop, itr,
        input  addr, flush, itr_act, depth, ovf, unf
    );

    modport slave (
        input  instr_addr, pc_l, isp_push, isp_pop, itr,
        output addr, flush, itr_act, depth, ovf, unf
    );
endinterface

// File: rtl/pc_stack.sv
// pc_stack: program counter plus hardware return-address stack.
// Ports: clk, rst (sync, active-high), bus (pc_stack_if.slave):
//   in  instr_addr, pc_l, isp_push, isp_pop, itr
//   out addr, flush, itr_act, depth, ovf, unf
module pc_stack #(
    parameter int MINSTW = 8,
    parameter int SDEPTH = 8,
    parameter int SPW    = $clog2(SDEPTH + 1)
) (
    input  logic       clk,
    input  logic       rst,
    pc_stack_if.slave  bus
);

    localparam int IW = (SDEPTH > 1) ? $clog2(SDEPTH) : 1;
    localparam logic [SPW-1:0] FULL = SPW'(SDEPTH);
    localparam logic [SPW-1:0] ONE  = SPW'(1);

    // tag = 1 marks an entry pushed by interrupt entry
    typedef struct packed {
        logic              tag;
        logic [MINSTW-1:0] a;
    } ent_t;

    ent_t              stack_q [SDEPTH];

    logic [MINSTW-1:0] addr_q, addr_d;
    logic [SPW-1:0]    depth_q, depth_d;
    logic [SPW-1:0]    icnt_q, icnt_d;
    logic              flush_q, flush_d;
    logic              itr_act_q, itr_act_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;

    logic              we;
    ent_t              wr_ent;
    ent_t              rd_ent;
    logic [IW-1:0]     wr_idx;
    logic [IW-1:0]     rd_idx;
    logic              full;
    logic              empty;
    logic [MINSTW-1:0] seq_addr;

    // pc_l only qualifies the other controls upstream; nothing here needs it
    logic              unused_pc_l;
    assign unused_pc_l = bus.pc_l;

    assign full     = (depth_q == FULL);
    assign empty    = (depth_q == '0);
    assign wr_idx   = depth_q[IW-1:0];
    assign rd_idx   = IW'(depth_q - ONE);
    assign rd_ent   = stack_q[rd_idx];
    assign seq_addr = bus.instr_addr + MINSTW'(1);

    // Event priority: itr > isp_pop > isp_push > sequential
    always_comb begin
        addr_d    = seq_addr;
        depth_d   = depth_q;
        icnt_d    = icnt_q;
        flush_d   = 1'b0;
        itr_act_d = itr_act_q;
        ovf_d     = ovf_q;
        unf_d     = unf_q;
        we        = 1'b0;
        wr_ent    = '{tag: 1'b0, a: addr_q};

        if (bus.itr) begin
            itr_act_d = 1'b1;
            if (full) begin
                ovf_d = 1'b1;
            end else begin
                we      = 1'b1;
                wr_ent  = '{tag: 1'b1, a: addr_q};
                depth_d = depth_q + ONE;
                icnt_d  = icnt_q + ONE;
            end
        end else if (bus.isp_pop) begin
            flush_d = 1'b1;
            if (empty) begin
                unf_d  = 1'b1;
                addr_d = '0;
            end else begin
                addr_d  = rd_ent.a;
                depth_d = depth_q - ONE;
                if (rd_ent.tag) begin
                    icnt_d    = icnt_q - ONE;
                    itr_act_d = (icnt_q != ONE);
                end
            end
        end else if (bus.isp_push) begin
            if (full) begin
                ovf_d = 1'b1;
            end else begin
                we      = 1'b1;
                depth_d = depth_q + ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q    <= '0;
            depth_q   <= '0;
            icnt_q    <= '0;
            flush_q   <= 1'b0;
            itr_act_q <= 1'b0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
        end else begin
            addr_q    <= addr_d;
            depth_q   <= depth_d;
            icnt_q    <= icnt_d;
            flush_q   <= flush_d;
            itr_act_q <= itr_act_d;
            ovf_q     <= ovf_d;
            unf_q     <= unf_d;
        end
    end

    // Stack contents are don't-care after reset, so no reset term here
    always_ff @(posedge clk) begin
        if (!rst && we) begin
            stack_q[wr_idx] <= wr_ent;
        end
    end

    assign bus.addr    = addr_q;
    assign bus.depth   = depth_q;
    assign bus.flush   = flush_q;
    assign bus.itr_act = itr_act_q;
    assign bus.ovf     = ovf_q;
    assign bus.unf     = unf_q;

endmodule

// File: tb/tb_pc_stack.sv
// tb_pc_stack: directed + random stimulus for pc_stack (MINSTW=8, SDEPTH=4)
// checked against a queue-based return-stack model.
module tb_pc_stack;

    localparam int MW = 8;
    localparam int SD = 4;
    localparam int SW = $clog2(SD + 1);

    typedef struct {
        logic [MW-1:0] a;
        bit            t;
    } ent_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pc_stack_if #(.MINSTW(MW), .SPW(SW)) bif ();

    pc_stack #(.MINSTW(MW), .SDEPTH(SD), .SPW(SW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    int checks = 0;
    int errors = 0;

    ent_t          q[$];
    logic [MW-1:0] m_addr;
    bit            m_flush, m_act, m_ovf, m_unf;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit any_tag();
        foreach (q[i]) if (q[i].t) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model(input bit r, input logic [MW-1:0] ia,
                         input bit pu, input bit po, input bit it);
        ent_t e;
        if (r) begin
            q.delete();
            m_addr = '0; m_flush = 0; m_act = 0; m_ovf = 0; m_unf = 0;
        end else if (it) begin
            if (q.size() == SD) m_ovf = 1;
            else q.push_back('{a: m_addr, t: 1'b1});
            m_act = 1; m_addr = ia + 8'd1; m_flush = 0;
        end else if (po) begin
            m_flush = 1;
            if (q.size() == 0) begin
                m_unf = 1; m_addr = '0;
            end else begin
                e = q.pop_back();
                m_addr = e.a;
                if (e.t && !any_tag()) m_act = 0;
            end
        end else begin
            if (pu) begin
                if (q.size() == SD) m_ovf = 1;
                else q.push_back('{a: m_addr, t: 1'b0});
            end
            m_addr = ia + 8'd1; m_flush = 0;
        end
    endtask

    task automatic step(input string tag, input bit r,
                        input logic [MW-1:0] ia, input bit pu,
                        input bit po, input bit it);
        rst = r;
        bif.instr_addr = ia;
        bif.isp_push = pu;
        bif.isp_pop = po;
        bif.itr = it;
        bif.pc_l = pu | po | it;
        @(posedge clk);
        model(r, ia, pu, po, it);
        #1;
        chk({tag, ".addr"},  32'(bif.addr),    32'(m_addr));
        chk({tag, ".depth"}, 32'(bif.depth),   32'(q.size()));
        chk({tag, ".flush"}, 32'(bif.flush),   32'(m_flush));
        chk({tag, ".act"},   32'(bif.itr_act), 32'(m_act));
        chk({tag, ".ovf"},   32'(bif.ovf),     32'(m_ovf));
        chk({tag, ".unf"},   32'(bif.unf),     32'(m_unf));
    endtask

    initial begin
        bit r, pu, po, it;
        logic [MW-1:0] ia;

        // reset and sequential fetch
        step("rst0", 1, 8'h00, 0, 0, 0);
        step("rst1", 1, 8'h00, 0, 0, 0);
        chk("rst_addr", 32'(bif.addr), 32'h0);
        step("seq0", 0, 8'h00, 0, 0, 0);
        step("seq1", 0, 8'h01, 0, 0, 0);
        step("seq2", 0, 8'h02, 0, 0, 0);
        chk("seq_addr3", 32'(bif.addr), 32'h3);
        step("wrap", 0, 8'hff, 0, 0, 0);
        chk("wrap_addr", 32'(bif.addr), 32'h0);

        // call / return
        step("pre", 0, 8'h10, 0, 0, 0);
        step("call", 0, 8'h40, 1, 0, 0);
        chk("call_addr", 32'(bif.addr), 32'h41);
        step("ret", 0, 8'h77, 0, 1, 0);
        chk("ret_addr", 32'(bif.addr), 32'h11);
        chk("ret_flush", 32'(bif.flush), 32'h1);
        step("post", 0, 8'h12, 0, 0, 0);

        // nested interrupt
        step("n_pre", 0, 8'h20, 0, 0, 0);
        step("n_call", 0, 8'h30, 1, 0, 0);
        step("n_itr", 0, 8'h02, 0, 0, 1);
        chk("n_itr_addr", 32'(bif.addr), 32'h3);
        chk("n_itr_act", 32'(bif.itr_act), 32'h1);
        step("n_pop1", 0, 8'h05, 0, 1, 0);
        chk("n_pop1_act", 32'(bif.itr_act), 32'h0);
        step("n_pop2", 0, 8'h05, 0, 1, 0);
        chk("n_pop2_addr", 32'(bif.addr), 32'h21);

        // overflow then LIFO drain
        for (int i = 0; i < 5; i++)
            step("o_push", 0, 8'(8'h50 + 8'(i * 16)), 1, 0, 0);
        chk("o_depth", 32'(bif.depth), 32'(SD));
        chk("o_ovf", 32'(bif.ovf), 32'h1);
        for (int i = 0; i < 4; i++)
            step("o_pop", 0, 8'h00, 0, 1, 0);

        // underflow
        step("u_pop", 0, 8'h33, 0, 1, 0);
        chk("u_unf", 32'(bif.unf), 32'h1);
        chk("u_addr", 32'(bif.addr), 32'h0);

        // collisions
        step("c_push", 0, 8'h60, 1, 0, 0);
        step("c_itrpop", 0, 8'h70, 0, 1, 1);
        chk("c_depth", 32'(bif.depth), 32'h2);
        step("c_push2", 0, 8'h80, 1, 0, 0);
        step("c_rst", 1, 8'h90, 1, 1, 1);
        chk("c_rst_depth", 32'(bif.depth), 32'h0);

        // random traffic
        for (int n = 0; n < 2000; n++) begin
            r  = ($urandom_range(0, 59) == 0);
            ia = 8'($urandom);
            it = ($urandom_range(0, 7) == 0);
            po = ($urandom_range(0, 3) == 0);
            pu = ($urandom_range(0, 3) == 0);
            step("rnd", r, ia, pu, po, it);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
